// File: rtl/alu_share_arb.sv
// alu_share_arb
//
// Shares one combinational ALU between two requesters (for example the
// integer pipeline and the load/store address generator). A round-robin
// arbiter grants at most one request per cycle. The winner's operation is
// driven onto the shared ALU ports. The ALU result is captured into a
// one-entry response register owned by that requester, which gives exactly
// one cycle of latency.
//
// Parameters
//   TAG_W    width of the opaque tag carried from request to response
//   RR_INIT  reset value of the last-grant pointer (1 => req0 wins first tie)
//
// Ports (x = 0,1)
//   clk_i, rst_ni           clock (rising edge), asynchronous active-low reset
//   reqx_valid_i/ready_o    request handshake; ready_o is the grant
//   reqx_op1_i/op2_i        operands
//   reqx_alu_op_i           ALU function select
//   reqx_shamt_i/shdir_i    shift amount / arithmetic-right select
//   reqx_sbtr_i             subtract select
//   reqx_tag_i              tag returned with the result
//   rspx_valid_o/ready_i    response handshake
//   rspx_data_o/tag_o       captured ALU result and originating tag
//   alu_*_o                 drive of the shared ALU (all zero when idle)
//   alu_res_i               shared ALU result, same cycle

module alu_share_arb #(
    parameter int TAG_W   = 2,
    parameter bit RR_INIT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [31:0]      req0_op1_i,
    input  logic [31:0]      req0_op2_i,
    input  logic [2:0]       req0_alu_op_i,
    input  logic [4:0]       req0_shamt_i,
    input  logic             req0_shdir_i,
    input  logic             req0_sbtr_i,
    input  logic [TAG_W-1:0] req0_tag_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [31:0]      req1_op1_i,
    input  logic [31:0]      req1_op2_i,
    input  logic [2:0]       req1_alu_op_i,
    input  logic [4:0]       req1_shamt_i,
    input  logic             req1_shdir_i,
    input  logic             req1_sbtr_i,
    input  logic [TAG_W-1:0] req1_tag_i,

    output logic             rsp0_valid_o,
    input  logic             rsp0_ready_i,
    output logic [31:0]      rsp0_data_o,
    output logic [TAG_W-1:0] rsp0_tag_o,

    output logic             rsp1_valid_o,
    input  logic             rsp1_ready_i,
    output logic [31:0]      rsp1_data_o,
    output logic [TAG_W-1:0] rsp1_tag_o,

    output logic [31:0]      alu_op1_o,
    output logic [31:0]      alu_op2_o,
    output logic [2:0]       alu_op_o,
    output logic [4:0]       alu_shamt_o,
    output logic             alu_shdir_o,
    output logic             alu_sbtr_o,
    input  logic [31:0]      alu_res_i
);

    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;
    logic last_grant;   // 0: req0 granted most recently, 1: req1

    // A response slot that drains this cycle counts as free, so a requester
    // with its consumer ready can issue back to back. Grants are suppressed
    // while reset is asserted so no handshake completes in reset.
    always_comb begin
        elig0  = req0_valid_i & (~rsp0_valid_o | rsp0_ready_i);
        elig1  = req1_valid_i & (~rsp1_valid_o | rsp1_ready_i);
        grant0 = rst_ni & elig0 & (~elig1 | last_grant);
        grant1 = rst_ni & elig1 & (~elig0 | ~last_grant);
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    // Idle cycles present an ADD of zeros to keep the shared ALU quiet.
    always_comb begin
        alu_op1_o   = '0;
        alu_op2_o   = '0;
        alu_op_o    = '0;
        alu_shamt_o = '0;
        alu_shdir_o = 1'b0;
        alu_sbtr_o  = 1'b0;
        if (grant0) begin
            alu_op1_o   = req0_op1_i;
            alu_op2_o   = req0_op2_i;
            alu_op_o    = req0_alu_op_i;
            alu_shamt_o = req0_shamt_i;
            alu_shdir_o = req0_shdir_i;
            alu_sbtr_o  = req0_sbtr_i;
        end else if (grant1) begin
            alu_op1_o   = req1_op1_i;
            alu_op2_o   = req1_op2_i;
            alu_op_o    = req1_alu_op_i;
            alu_shamt_o = req1_shamt_i;
            alu_shdir_o = req1_shdir_i;
            alu_sbtr_o  = req1_sbtr_i;
        end
    end

    // Pointer moves only on a grant; idle cycles keep the fairness order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant <= RR_INIT;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

    // Response registers. A refill takes priority over a drain, so a slot
    // that is consumed and refilled in the same cycle stays valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp0_valid_o <= 1'b0;
            rsp0_data_o  <= '0;
            rsp0_tag_o   <= '0;
        end else if (grant0) begin
            rsp0_valid_o <= 1'b1;
            rsp0_data_o  <= alu_res_i;
            rsp0_tag_o   <= req0_tag_i;
        end else if (rsp0_ready_i) begin
            rsp0_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp1_valid_o <= 1'b0;
            rsp1_data_o  <= '0;
            rsp1_tag_o   <= '0;
        end else if (grant1) begin
            rsp1_valid_o <= 1'b1;
            rsp1_data_o  <= alu_res_i;
            rsp1_tag_o   <= req1_tag_i;
        end else if (rsp1_ready_i) begin
            rsp1_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb
//
// Bench for alu_share_arb. Provides a behavioural stand-in for the shared
// ALU, a transaction-level model of the arbiter and response slots, a
// per-cycle compare process, and directed stimulus with literal checks.

module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid [2];
    logic [31:0] req_op1   [2];
    logic [31:0] req_op2   [2];
    logic [2:0]  req_op    [2];
    logic [4:0]  req_shamt [2];
    logic        req_shdir [2];
    logic        req_sbtr  [2];
    logic [1:0]  req_tag   [2];
    logic        rsp_ready [2];

    logic        req_rdy   [2];
    logic        rsp_vld   [2];
    logic [31:0] rsp_data  [2];
    logic [1:0]  rsp_tag   [2];

    logic [31:0] alu_op1, alu_op2, alu_res;
    logic [2:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic        alu_shdir, alu_sbtr;

    int checks = 0;
    int errors = 0;
    logic acc [2];

    // Model state: what each response slot must hold and who was served last.
    logic        m_vld  [2];
    logic [31:0] m_data [2];
    logic [1:0]  m_tag  [2];
    logic        m_last;

    always #5 clk = ~clk;

    alu_share_arb #(.TAG_W(2), .RR_INIT(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(req_valid[0]), .req0_ready_o(req_rdy[0]),
        .req0_op1_i(req_op1[0]), .req0_op2_i(req_op2[0]),
        .req0_alu_op_i(req_op[0]), .req0_shamt_i(req_shamt[0]),
        .req0_shdir_i(req_shdir[0]), .req0_sbtr_i(req_sbtr[0]),
        .req0_tag_i(req_tag[0]),
        .req1_valid_i(req_valid[1]), .req1_ready_o(req_rdy[1]),
        .req1_op1_i(req_op1[1]), .req1_op2_i(req_op2[1]),
        .req1_alu_op_i(req_op[1]), .req1_shamt_i(req_shamt[1]),
        .req1_shdir_i(req_shdir[1]), .req1_sbtr_i(req_sbtr[1]),
        .req1_tag_i(req_tag[1]),
        .rsp0_valid_o(rsp_vld[0]), .rsp0_ready_i(rsp_ready[0]),
        .rsp0_data_o(rsp_data[0]), .rsp0_tag_o(rsp_tag[0]),
        .rsp1_valid_o(rsp_vld[1]), .rsp1_ready_i(rsp_ready[1]),
        .rsp1_data_o(rsp_data[1]), .rsp1_tag_o(rsp_tag[1]),
        .alu_op1_o(alu_op1), .alu_op2_o(alu_op2), .alu_op_o(alu_op),
        .alu_shamt_o(alu_shamt), .alu_shdir_o(alu_shdir), .alu_sbtr_o(alu_sbtr),
        .alu_res_i(alu_res)
    );

    // Shared ALU stand-in: 0 add/sub, 1 shift, 2 and, 3 or, 4 xor.
    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh,
                                           input logic shdir, input logic sbtr);
        case (op)
            3'd0:    return sbtr ? a - b : a + b;
            3'd1:    return shdir ? 32'($signed(a) >>> sh) : a << sh;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_res = alu_fn(alu_op, alu_op1, alu_op2, alu_shamt, alu_shdir, alu_sbtr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Who must be served this cycle, as a one-hot {req1, req0}.
    function automatic logic [1:0] exp_grant();
        bit ok0, ok1;
        ok0 = req_valid[0] && (!m_vld[0] || rsp_ready[0]);
        ok1 = req_valid[1] && (!m_vld[1] || rsp_ready[1]);
        if (ok0 && ok1) return m_last ? 2'b01 : 2'b10;
        return {ok1, ok0};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [1:0] g;
        if (!rst_n) begin
            for (int x = 0; x < 2; x++) begin
                m_vld[x]  <= 1'b0;
                m_data[x] <= '0;
                m_tag[x]  <= '0;
            end
            m_last <= 1'b1;
        end else begin
            g = exp_grant();
            for (int x = 0; x < 2; x++) begin
                if (g[x]) begin
                    m_vld[x]  <= 1'b1;
                    m_data[x] <= alu_fn(req_op[x], req_op1[x], req_op2[x],
                                        req_shamt[x], req_shdir[x], req_sbtr[x]);
                    m_tag[x]  <= req_tag[x];
                end else if (rsp_ready[x]) begin
                    m_vld[x] <= 1'b0;
                end
            end
            if (g != 2'b00) m_last <= g[1];
        end
    end

    always @(negedge clk) begin
        logic [1:0] g;
        int w;
        if (rst_n === 1'b1) begin
            g = exp_grant();
            chk("m_req0_ready", 32'(req_rdy[0]), 32'(g[0]));
            chk("m_req1_ready", 32'(req_rdy[1]), 32'(g[1]));
            w = g[1] ? 1 : 0;
            if (g != 2'b00) begin
                chk("m_alu_op1", alu_op1, req_op1[w]);
                chk("m_alu_op2", alu_op2, req_op2[w]);
                chk("m_alu_ctl", {21'd0, alu_op, alu_shamt, alu_shdir, alu_sbtr},
                    {21'd0, req_op[w], req_shamt[w], req_shdir[w], req_sbtr[w]});
            end else begin
                chk("m_alu_idle", alu_op1 | alu_op2 | {21'd0, alu_op, alu_shamt, alu_shdir, alu_sbtr}, 32'd0);
            end
            for (int x = 0; x < 2; x++) begin
                chk($sformatf("m_rsp%0d_valid", x), 32'(rsp_vld[x]), 32'(m_vld[x]));
                chk($sformatf("m_rsp%0d_data", x), rsp_data[x], m_data[x]);
                chk($sformatf("m_rsp%0d_tag", x), 32'(rsp_tag[x]), 32'(m_tag[x]));
            end
        end
    end

    task automatic step();
        acc[0] = req_rdy[0];
        acc[1] = req_rdy[1];
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int x, input logic v, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                           input logic shdir, input logic sbtr, input logic [1:0] tag);
        req_valid[x] = v;  req_op[x]    = op;    req_op1[x]  = a;    req_op2[x] = b;
        req_shamt[x] = sh; req_shdir[x] = shdir; req_sbtr[x] = sbtr; req_tag[x] = tag;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int x = 0; x < 2; x++) begin
            set_req(x, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'd0);
            rsp_ready[x] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int x = 0; x < 2; x++) begin
            chk("rst_valid", 32'(rsp_vld[x]), 0);
            chk("rst_data", rsp_data[x], 0);
            chk("rst_tag", 32'(rsp_tag[x]), 0);
        end
        rst_n = 1'b1;

        // 1: tie on the first cycle after reset goes to req0
        set_req(0, 1'b1, 3'd0, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0, 2'd1);
        set_req(1, 1'b1, 3'd0, 32'd9, 32'd4, 5'd0, 1'b0, 1'b1, 2'd2);
        #1;
        chk("t1_rdy0", 32'(req_rdy[0]), 1);
        chk("t1_rdy1", 32'(req_rdy[1]), 0);
        step();
        req_valid[0] = 1'b0;
        #1;
        chk("t1_rsp0_valid", 32'(rsp_vld[0]), 1);
        chk("t1_rsp0_data", rsp_data[0], 12);
        chk("t1_rsp0_tag", 32'(rsp_tag[0]), 1);
        chk("t1_rdy1_next", 32'(req_rdy[1]), 1);
        step();
        req_valid[1] = 1'b0;
        #1;
        chk("t1_rsp1_valid", 32'(rsp_vld[1]), 1);
        chk("t1_rsp1_data", rsp_data[1], 5);

        // 2: continuous contention alternates 0,1,0,1
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_rdy0", 32'(req_rdy[0]), (k % 2 == 0) ? 1 : 0);
            step();
            for (int x = 0; x < 2; x++)
                if (acc[x])
                    set_req(x, 1'b1, 3'(k % 5), 32'(k * 37 + x), 32'(x + 3),
                            5'(k + 1), k[0], k[1], 2'(k + x));
        end

        // 3: stalled rsp0 blocks only req0
        rsp_ready[0] = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_rdy0", 32'(req_rdy[0]), 0);
            chk("t3_rdy1", 32'(req_rdy[1]), 1);
            step();
            set_req(1, 1'b1, 3'd2, 32'(32'hF0F0 + k), 32'hFF, 5'd0, 1'b0, 1'b0, 2'(k));
        end
        rsp_ready[0] = 1'b1;
        #1;
        chk("t3_release_rdy0", 32'(req_rdy[0]), 1);
        step();

        // 4: refill of rsp1 while it drains
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 3'd0, 32'd1, 32'd1, 5'd0, 1'b0, 1'b0, 2'd0);
        rsp_ready[1] = 1'b1;
        step();
        set_req(1, 1'b1, 3'd1, 32'h8000_0000, 32'd0, 5'd4, 1'b1, 1'b0, 2'd3);
        #1;
        chk("t4_pre_valid", 32'(rsp_vld[1]), 1);
        chk("t4_rdy1", 32'(req_rdy[1]), 1);
        step();
        req_valid[1] = 1'b0;
        #1;
        chk("t4_valid", 32'(rsp_vld[1]), 1);
        chk("t4_data", rsp_data[1], 32'hF800_0000);
        chk("t4_tag", 32'(rsp_tag[1]), 3);

        // 5: asynchronous reset with both responses held
        rsp_ready[0] = 1'b0;
        rsp_ready[1] = 1'b0;
        set_req(0, 1'b1, 3'd0, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0, 2'd0);
        set_req(1, 1'b1, 3'd0, 32'd3, 32'd4, 5'd0, 1'b0, 1'b0, 2'd1);
        step();
        step();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        #1;
        chk("t5_pre0", 32'(rsp_vld[0]), 1);
        chk("t5_pre1", 32'(rsp_vld[1]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst0", 32'(rsp_vld[0]), 0);
        chk("t5_rst1", 32'(rsp_vld[1]), 0);
        step();
        step();
        rst_n = 1'b1;
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        #1;
        chk("t5_tie_rdy0", 32'(req_rdy[0]), 1);
        chk("t5_tie_rdy1", 32'(req_rdy[1]), 0);
        step();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;

        // 6: idle cycles drive zeros and keep the pointer
        #1;
        chk("t6_alu_op1", alu_op1, 0);
        chk("t6_alu_op2", alu_op2, 0);
        chk("t6_alu_ctl", {21'd0, alu_op, alu_shamt, alu_shdir, alu_sbtr}, 0);
        chk("t6_rdy", 32'({req_rdy[1], req_rdy[0]}), 0);
        repeat (3) step();
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        #1;
        chk("t6_ptr_rdy1", 32'(req_rdy[1]), 1);
        step();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
